// File: rtl/pixel_scan_sampler.sv
// pixel_scan_sampler: walks a one-hot select over NUM_PIX taps, averages 2**AVG_LOG2 luma samples per tap, thresholds each tap to a dark bit.
// Latency: NUM_PIX*(SETTLE + 2**AVG_LOG2 + 1) + 2 cycles from the start pulse to bits_valid rising.
// Backpressure: none; the scan never stalls. An unacknowledged result is overwritten and sticky overrun is raised.
// Ports: clk/reset (async, active-high); start, continuous, threshold control a scan;
//        pixel_r/g/b are the selected tap's colour channels; pixel_select drives the tap mux;
//        bits/bits_valid/bits_ack form the result handshake; busy and overrun report status.
module pixel_scan_sampler #(
    parameter int NUM_PIX  = 8,
    parameter int PIX_W    = 8,
    parameter int SETTLE   = 4,
    parameter int AVG_LOG2 = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               continuous,
    input  logic [PIX_W+1:0]   threshold,
    input  logic [PIX_W-1:0]   pixel_r,
    input  logic [PIX_W-1:0]   pixel_g,
    input  logic [PIX_W-1:0]   pixel_b,
    output logic [NUM_PIX-1:0] pixel_select,
    output logic               busy,
    output logic [NUM_PIX-1:0] bits,
    output logic               bits_valid,
    input  logic               bits_ack,
    output logic               overrun
);

    localparam int NAVG    = 1 << AVG_LOG2;
    localparam int CNT_MAX = (SETTLE > NAVG) ? SETTLE : NAVG;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = $clog2(NUM_PIX);
    localparam int LUMA_W  = PIX_W + 2;
    localparam int ACC_W   = LUMA_W + AVG_LOG2;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] ACCUM_LAST  = CNT_W'(NAVG - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_PIX - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_ACCUM,
        S_STORE,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic [ACC_W-1:0]   r_acc;
    logic [LUMA_W-1:0]  r_thr;
    logic [NUM_PIX-1:0] r_shadow;
    logic [NUM_PIX-1:0] r_sel;
    logic [NUM_PIX-1:0] r_bits;
    logic               r_busy;
    logic               r_valid;
    logic               r_overrun;

    logic [LUMA_W-1:0]  w_luma;
    logic [LUMA_W-1:0]  w_avg;
    logic               w_dark;

    // luma = r + 2g + b; the doubled green is a shift, and the sum fits PIX_W+2 bits.
    assign w_luma = LUMA_W'(pixel_r) + {1'b0, pixel_g, 1'b0} + LUMA_W'(pixel_b);
    assign w_avg  = LUMA_W'(r_acc >> AVG_LOG2);
    // Equality counts as light.
    assign w_dark = (w_avg < r_thr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_acc     <= '0;
            r_thr     <= '0;
            r_shadow  <= '0;
            r_sel     <= '0;
            r_bits    <= '0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            // Consumer ack; the DONE branch below overrides this when a new result lands.
            if (bits_ack && r_valid) begin
                r_valid   <= 1'b0;
                r_overrun <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_thr   <= threshold;
                        r_idx   <= '0;
                        r_cnt   <= '0;
                        r_acc   <= '0;
                        r_sel   <= NUM_PIX'(1);
                        r_busy  <= 1'b1;
                        r_state <= S_SETTLE;
                    end
                end

                S_SETTLE: begin
                    if (r_cnt == SETTLE_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_ACCUM;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_ACCUM: begin
                    r_acc <= r_acc + ACC_W'(w_luma);
                    if (r_cnt == ACCUM_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_STORE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_STORE: begin
                    r_shadow[r_idx] <= w_dark;
                    if (r_idx == IDX_LAST) begin
                        r_sel   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_idx   <= r_idx + IDX_W'(1);
                        r_sel   <= r_sel << 1;
                        r_acc   <= '0;
                        r_state <= S_SETTLE;
                    end
                end

                S_DONE: begin
                    r_bits  <= r_shadow;
                    r_valid <= 1'b1;
                    // An ack landing in this very cycle consumes the old word, so no overrun.
                    r_overrun <= r_valid && !bits_ack;
                    if (continuous) begin
                        r_thr   <= threshold;
                        r_idx   <= '0;
                        r_acc   <= '0;
                        r_sel   <= NUM_PIX'(1);
                        r_state <= S_SETTLE;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign pixel_select = r_sel;
    assign busy         = r_busy;
    assign bits         = r_bits;
    assign bits_valid   = r_valid;
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_pixel_scan_sampler.sv
// tb_pixel_scan_sampler: directed scans against a scan-level timing model plus hand-computed literals.
// Latency: checks the start-to-bits_valid latency of single scans.
// Backpressure: exercises ack timing, overrun on unacknowledged results, and ack in the DONE cycle.
module tb_pixel_scan_sampler;

    localparam int NUM_PIX  = 8;
    localparam int PIX_W    = 8;
    localparam int SETTLE   = 4;
    localparam int AVG_LOG2 = 2;
    localparam int NAVG     = 1 << AVG_LOG2;
    localparam int P        = SETTLE + NAVG + 1;   // cycles per tap
    localparam int L        = NUM_PIX * P;         // cycles spent on taps per scan

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic               continuous = 1'b0;
    logic [PIX_W+1:0]   threshold = '0;
    logic [PIX_W-1:0]   pixel_r;
    logic [PIX_W-1:0]   pixel_g;
    logic [PIX_W-1:0]   pixel_b;
    logic [NUM_PIX-1:0] pixel_select;
    logic               busy;
    logic [NUM_PIX-1:0] bits;
    logic               bits_valid;
    logic               bits_ack = 1'b0;
    logic               overrun;

    logic [PIX_W-1:0] tap_r [NUM_PIX];
    logic [PIX_W-1:0] tap_g [NUM_PIX];
    logic [PIX_W-1:0] tap_b [NUM_PIX];

    int n_checks = 0;
    int n_fail   = 0;

    pixel_scan_sampler #(
        .NUM_PIX (NUM_PIX),
        .PIX_W   (PIX_W),
        .SETTLE  (SETTLE),
        .AVG_LOG2(AVG_LOG2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .continuous  (continuous),
        .threshold   (threshold),
        .pixel_r     (pixel_r),
        .pixel_g     (pixel_g),
        .pixel_b     (pixel_b),
        .pixel_select(pixel_select),
        .busy        (busy),
        .bits        (bits),
        .bits_valid  (bits_valid),
        .bits_ack    (bits_ack),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // Sensor array: the selected tap's colours appear on the pixel inputs.
    int sel_idx;
    always_comb begin
        sel_idx = 0;
        for (int i = 0; i < NUM_PIX; i++)
            if (pixel_select[i]) sel_idx = i;
    end
    assign pixel_r = tap_r[sel_idx];
    assign pixel_g = tap_g[sel_idx];
    assign pixel_b = tap_b[sel_idx];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scan-level model ----------------
    // Tap inputs are held constant for a whole scan, so every averaged sample of a tap
    // equals that tap's luma and the mean is the luma itself.
    function automatic logic [NUM_PIX-1:0] expect_bits(input int thr);
        logic [NUM_PIX-1:0] res;
        res = '0;
        for (int i = 0; i < NUM_PIX; i++) begin
            int luma;
            luma = int'(tap_r[i]) + 2 * int'(tap_g[i]) + int'(tap_b[i]);
            res[i] = (luma < thr);
        end
        return res;
    endfunction

    bit                 m_active = 1'b0;
    int                 m_t      = 0;   // cycle index within the scan; DONE is L+1
    logic [NUM_PIX-1:0] m_scan   = '0;
    logic [NUM_PIX-1:0] m_bits   = '0;
    bit                 m_valid  = 1'b0;
    bit                 m_ovr    = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_active <= 1'b0;
            m_t      <= 0;
            m_scan   <= '0;
            m_bits   <= '0;
            m_valid  <= 1'b0;
            m_ovr    <= 1'b0;
        end else begin
            if (bits_ack && m_valid) begin
                m_valid <= 1'b0;
                m_ovr   <= 1'b0;
            end
            if (!m_active) begin
                if (start) begin
                    m_active <= 1'b1;
                    m_t      <= 1;
                    m_scan   <= expect_bits(int'(threshold));
                end
            end else if (m_t == L + 1) begin
                m_bits  <= m_scan;
                m_valid <= 1'b1;
                m_ovr   <= m_valid && !bits_ack;
                if (continuous) begin
                    m_t    <= 1;
                    m_scan <= expect_bits(int'(threshold));
                end else begin
                    m_active <= 1'b0;
                    m_t      <= 0;
                end
            end else begin
                m_t <= m_t + 1;
            end
        end
    end

    always @(negedge clk) begin
        check("busy", 32'(busy), 32'(m_active));
        // The select during the single DONE cycle is left unchecked.
        if (!(m_active && m_t == L + 1))
            check("pixel_select", 32'(pixel_select),
                  m_active ? (32'd1 << ((m_t - 1) / P)) : 32'd0);
        check("bits", 32'(bits), 32'(m_bits));
        check("bits_valid", 32'(bits_valid), 32'(m_valid));
        check("overrun", 32'(overrun), 32'(m_ovr));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic do_ack();
        bits_ack = 1'b1;
        tick(1);
        bits_ack = 1'b0;
    endtask

    task automatic set_tap(input int i, input logic [PIX_W-1:0] r,
                           input logic [PIX_W-1:0] g, input logic [PIX_W-1:0] b);
        tap_r[i] = r;
        tap_g[i] = g;
        tap_b[i] = b;
    endtask

    // Start a scan with bits_valid low and count cycles until it rises.
    task automatic scan_measure(input bit walk, output int lat);
        start = 1'b1;
        lat   = 0;
        do begin
            tick(1);
            start = 1'b0;
            lat++;
            if (walk && lat == 1)  check("walk_t1", 32'(pixel_select), 32'h01);
            if (walk && lat == 45) check("walk_t45", 32'(pixel_select), 32'h10);
            if (walk && lat == 46) check("walk_t46", 32'(pixel_select), 32'h20);
        end while (!bits_valid && lat < 300);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && busy; i++) tick(1);
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Distinct luma per tap: {40,200,360,520,680,840,1000,120}.
    task automatic load_ramp();
        logic [PIX_W-1:0] v [NUM_PIX];
        v = '{8'd10, 8'd50, 8'd90, 8'd130, 8'd170, 8'd210, 8'd250, 8'd30};
        for (int i = 0; i < NUM_PIX; i++) set_tap(i, v[i], v[i], v[i]);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, elapsed %0t, expected under 1000000", $time);
        $fatal(1);
    end

    initial begin
        int lat;
        for (int i = 0; i < NUM_PIX; i++) set_tap(i, 8'd0, 8'd0, 8'd0);
        tick(3);
        reset = 1'b0;
        tick(1);
        check("rst_sel", 32'(pixel_select), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bits", 32'(bits), 32'd0);
        check("rst_valid", 32'(bits_valid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);

        // 1: green 200 everywhere (luma 400), threshold 300 -> all light.
        for (int i = 0; i < NUM_PIX; i++) set_tap(i, 8'd0, 8'd200, 8'd0);
        threshold = 10'd300;
        scan_measure(1'b1, lat);
        check("t1_latency", 32'(lat), 32'd74);
        check("t1_bits", 32'(bits), 32'h00);
        wait_idle();
        do_ack();
        check("t1_ack_valid", 32'(bits_valid), 32'd0);

        // 2: dark taps 0,3,7 (luma 40), others luma 1020, threshold 512.
        //    A start pulse mid-scan must be ignored.
        for (int i = 0; i < NUM_PIX; i++) set_tap(i, 8'd255, 8'd255, 8'd255);
        set_tap(0, 8'd10, 8'd10, 8'd10);
        set_tap(3, 8'd10, 8'd10, 8'd10);
        set_tap(7, 8'd10, 8'd10, 8'd10);
        threshold = 10'd512;
        pulse_start();
        tick(20);
        pulse_start();
        wait_idle();
        check("t2_bits", 32'(bits), 32'h89);
        check("t2_valid", 32'(bits_valid), 32'd1);
        do_ack();

        // 3: luma 400 on every tap; equal threshold -> light, one above -> dark.
        for (int i = 0; i < NUM_PIX; i++) set_tap(i, 8'd100, 8'd100, 8'd100);
        threshold = 10'd400;
        scan_measure(1'b0, lat);
        check("t3_eq_bits", 32'(bits), 32'h00);
        wait_idle();
        do_ack();
        threshold = 10'd401;
        scan_measure(1'b0, lat);
        check("t3_above_bits", 32'(bits), 32'hFF);
        wait_idle();
        do_ack();

        // 4: continuous, no ack across two scans. Scan 1 latches 300 (0x83),
        //    scan 2 relatches 700 at DONE (0x9F) and overruns.
        load_ramp();
        continuous = 1'b1;
        threshold  = 10'd300;
        pulse_start();
        threshold = 10'd700;
        tick(73);
        check("t4_scan1_bits", 32'(bits), 32'h83);
        check("t4_scan1_ovr", 32'(overrun), 32'd0);
        tick(73);
        check("t4_scan2_bits", 32'(bits), 32'h9F);
        check("t4_scan2_valid", 32'(bits_valid), 32'd1);
        check("t4_scan2_ovr", 32'(overrun), 32'd1);
        do_ack();
        check("t4_ack_valid", 32'(bits_valid), 32'd0);
        check("t4_ack_ovr", 32'(overrun), 32'd0);
        continuous = 1'b0;
        wait_idle();
        check("t4_scan3_bits", 32'(bits), 32'h9F);
        do_ack();

        // 5: ack exactly in the DONE cycle of scan 2.
        continuous = 1'b1;
        threshold  = 10'd300;
        pulse_start();
        threshold = 10'd700;
        tick(145);
        bits_ack   = 1'b1;
        continuous = 1'b0;
        tick(1);
        bits_ack = 1'b0;
        check("t5_valid", 32'(bits_valid), 32'd1);
        check("t5_ovr", 32'(overrun), 32'd0);
        check("t5_bits", 32'(bits), 32'h9F);
        check("t5_busy", 32'(busy), 32'd0);

        // 6: reset during ACCUM of tap 4, then a clean scan.
        threshold = 10'd300;
        pulse_start();
        tick(41);
        check("t6_pre_sel", 32'(pixel_select), 32'h10);
        reset = 1'b1;
        #1;
        check("t6_rst_sel", 32'(pixel_select), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_bits", 32'(bits), 32'd0);
        check("t6_rst_valid", 32'(bits_valid), 32'd0);
        check("t6_rst_ovr", 32'(overrun), 32'd0);
        tick(1);
        reset = 1'b0;
        tick(1);
        scan_measure(1'b0, lat);
        check("t6_latency", 32'(lat), 32'd74);
        check("t6_bits", 32'(bits), 32'h83);
        wait_idle();
        do_ack();
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
